lru_list_arb: RTL

LRU_LIST_ARB -- requirements
Module: lru_list_arb

---
 rtl/lru_list_arb_if.sv | 28 ++
 rtl/lru_list_arb.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/lru_list_arb_if.sv
// Requester-side bundle for lru_list_arb: per-port request/command/tag in,
// grant and registered response out, plus list occupancy counts.
interface lru_list_arb_if #(
  parameter int DEPTH     = 8,
  parameter int NUM_PORTS = 2
);
  localparam int TW = $clog2(DEPTH);

  logic [NUM_PORTS-1:0]    req;
  logic [2*NUM_PORTS-1:0]  cmd;
  logic [TW*NUM_PORTS-1:0] tag_in;
  logic [NUM_PORTS-1:0]    gnt;
  logic [NUM_PORTS-1:0]    rsp_valid;
  logic [2*NUM_PORTS-1:0]  rsp_status;
  logic [TW*NUM_PORTS-1:0] rsp_tag;
  logic [TW:0]             free_cnt;
  logic [TW:0]             lru_cnt;

  modport master (
    output req, cmd, tag_in,
    input  gnt, rsp_valid, rsp_status, rsp_tag, free_cnt, lru_cnt
  );

  modport slave (
    input  req, cmd, tag_in,
    output gnt, rsp_valid, rsp_status, rsp_tag, free_cnt, lru_cnt
  );
endinterface

// File: rtl/lru_list_arb.sv
// Round-robin arbitrated free/LRU doubly-linked tag lists sharing one pointer table.
// Latency: grant is combinational, list update at the grant-cycle edge, response one cycle later.
// Backpressure: requesters hold req until gnt; ungranted ports simply wait.
module lru_list_arb #(
  parameter int DEPTH     = 8,
  parameter int NUM_PORTS = 2
) (
  input logic           clk,
  input logic           rst_n,
  lru_list_arb_if.slave bus
);
  localparam int TW = $clog2(DEPTH);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [1:0] CMD_ALLOC       = 2'b00;
  localparam logic [1:0] CMD_TOUCH       = 2'b01;
  localparam logic [1:0] CMD_ALLOC_EVICT = 2'b11;
  localparam logic [1:0] ST_OK           = 2'b00;
  localparam logic [1:0] ST_EVICTED      = 2'b01;
  localparam logic [1:0] ST_EMPTY        = 2'b10;
  localparam logic [1:0] ST_BADTAG       = 2'b11;
  localparam logic [TW:0] CNT_ONE        = 1;

  logic [TW-1:0]           r_prev [DEPTH];
  logic [TW-1:0]           r_next [DEPTH];
  logic [DEPTH-1:0]        r_in_lru;
  logic [TW-1:0]           r_fh, r_ft, r_lh, r_lt;
  logic [TW:0]             r_fc, r_lc;
  logic [PW-1:0]           r_rr_ptr;
  logic [NUM_PORTS-1:0]    r_rsp_valid;
  logic [2*NUM_PORTS-1:0]  r_rsp_status;
  logic [TW*NUM_PORTS-1:0] r_rsp_tag;

  logic [TW-1:0]           w_prev [DEPTH];
  logic [TW-1:0]           w_next [DEPTH];
  logic [DEPTH-1:0]        w_in_lru;
  logic [TW-1:0]           w_fh, w_ft, w_lh, w_lt;
  logic [TW:0]             w_fc, w_lc;
  logic [NUM_PORTS-1:0]    w_gnt;
  logic [PW-1:0]           w_gnt_idx;
  logic                    w_any;
  logic [1:0]              w_cmd, w_status;
  logic [TW-1:0]           w_tag, w_rtag, w_op_tag, w_p, w_n;
  logic                    w_move;

  // First requester at or after the pointer wins; pointer holds the port after the last grant.
  always_comb begin
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_any     = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!w_any && bus.req[(int'(r_rr_ptr) + k) % NUM_PORTS]) begin
        w_any     = 1'b1;
        w_gnt_idx = PW'((int'(r_rr_ptr) + k) % NUM_PORTS);
      end
    end
    if (w_any) w_gnt[w_gnt_idx] = 1'b1;
  end

  assign w_cmd    = bus.cmd[2*int'(w_gnt_idx) +: 2];
  assign w_tag    = bus.tag_in[TW*int'(w_gnt_idx) +: TW];
  assign w_op_tag = (w_cmd == CMD_ALLOC_EVICT) ? r_lt : w_tag;
  assign w_p      = r_prev[w_op_tag];
  assign w_n      = r_next[w_op_tag];

  always_comb begin
    w_prev   = r_prev;
    w_next   = r_next;
    w_in_lru = r_in_lru;
    w_fh = r_fh;  w_ft = r_ft;  w_fc = r_fc;
    w_lh = r_lh;  w_lt = r_lt;  w_lc = r_lc;
    w_status = ST_OK;
    w_rtag   = w_tag;
    w_move   = 1'b0;
    if (w_any) begin
      case (w_cmd)
        CMD_ALLOC, CMD_ALLOC_EVICT: begin
          if (r_fc != '0) begin
            w_rtag           = r_fh;
            w_fh             = r_next[r_fh];
            w_fc             = r_fc - CNT_ONE;
            w_in_lru[r_fh]   = 1'b1;
            w_next[r_fh]     = r_lh;
            if (r_lc == '0) w_lt = r_fh;
            else            w_prev[r_lh] = r_fh;
            w_lh             = r_fh;
            w_lc             = r_lc + CNT_ONE;
          end else if (w_cmd == CMD_ALLOC) begin
            w_status = ST_EMPTY;
            w_rtag   = '0;
          end else begin
            w_status = ST_EVICTED;
            w_rtag   = r_lt;
            w_move   = (r_lt != r_lh);
          end
        end
        CMD_TOUCH: begin
          if (!r_in_lru[w_tag]) w_status = ST_BADTAG;
          else                  w_move   = (w_tag != r_lh);
        end
        default: begin
          // FREE: unlink from LRU, append at free tail; rejected if already free.
          if (!r_in_lru[w_tag]) begin
            w_status = ST_BADTAG;
          end else begin
            if (w_tag == r_lh) w_lh = w_n;
            else               w_next[w_p] = w_n;
            if (w_tag == r_lt) w_lt = w_p;
            else               w_prev[w_n] = w_p;
            w_lc            = r_lc - CNT_ONE;
            w_in_lru[w_tag] = 1'b0;
            if (r_fc == '0) w_fh = w_tag;
            else            w_next[r_ft] = w_tag;
            w_prev[w_tag]   = r_ft;
            w_ft            = w_tag;
            w_fc            = r_fc + CNT_ONE;
          end
        end
      endcase
    end
    // Move-to-MRU of a non-head LRU member (list holds at least two tags here).
    if (w_move) begin
      w_next[w_p] = w_n;
      if (w_op_tag == r_lt) w_lt = w_p;
      else                  w_prev[w_n] = w_p;
      w_next[w_op_tag] = r_lh;
      w_prev[r_lh]     = w_op_tag;
      w_lh             = w_op_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_next[i] <= TW'(i + 1);
        r_prev[i] <= TW'(i - 1);
      end
      r_in_lru     <= '0;
      r_fh         <= '0;
      r_ft         <= TW'(DEPTH - 1);
      r_fc         <= (TW+1)'(DEPTH);
      r_lh         <= '0;
      r_lt         <= '0;
      r_lc         <= '0;
      r_rr_ptr     <= '0;
      r_rsp_valid  <= '0;
      r_rsp_status <= '0;
      r_rsp_tag    <= '0;
    end else begin
      r_prev      <= w_prev;
      r_next      <= w_next;
      r_in_lru    <= w_in_lru;
      r_fh        <= w_fh;
      r_ft        <= w_ft;
      r_fc        <= w_fc;
      r_lh        <= w_lh;
      r_lt        <= w_lt;
      r_lc        <= w_lc;
      r_rsp_valid <= w_gnt;
      if (w_any) begin
        r_rr_ptr                                <= PW'((int'(w_gnt_idx) + 1) % NUM_PORTS);
        r_rsp_status[2*int'(w_gnt_idx) +: 2]    <= w_status;
        r_rsp_tag[TW*int'(w_gnt_idx) +: TW]     <= w_rtag;
      end
    end
  end

  assign bus.gnt        = w_gnt;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_status = r_rsp_status;
  assign bus.rsp_tag    = r_rsp_tag;
  assign bus.free_cnt   = r_fc;
  assign bus.lru_cnt    = r_lc;
endmodule
